// File: rtl/rob_multiway.sv
// rob_multiway: multi-lane reorder buffer. Dispatches up to WIDTH entries per
// cycle at the tail, marks entries complete by index, and retires up to WIDTH
// completed entries per cycle from the head in program order.
// Optional feature macro: ROB_FLUSH_EN adds a flush port that squashes every
// in-flight entry at the next edge.
module rob_multiway #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 2,
  parameter int TAG_W = 7,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [WIDTH-1:0]                disp_valid,
  input  logic [WIDTH-1:0][TAG_W:0]       disp_t,
  input  logic [WIDTH-1:0][TAG_W:0]       disp_t_old,
  output logic [WIDTH-1:0][IDX_W-1:0]     disp_idx,
  output logic [IDX_W:0]                  free_count,
  output logic                            disp_accept,
  input  logic [WIDTH-1:0]                cmpl_en,
  input  logic [WIDTH-1:0][IDX_W-1:0]     cmpl_idx,
  output logic [WIDTH-1:0]                retire_valid,
  output logic [WIDTH-1:0][TAG_W:0]       retire_t,
  output logic [WIDTH-1:0][TAG_W:0]       retire_t_old
`ifdef ROB_FLUSH_EN
  ,
  input  logic                            flush
`endif
);

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  logic [TAG_W:0]   t_q     [DEPTH];
  logic [TAG_W:0]   t_old_q [DEPTH];
  logic [DEPTH-1:0] cmpl_q, cmpl_d;
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d, free_q, free_d;
  logic [IDX_W:0]   n_disp, n_ret;
  logic [IDX_W-1:0] ridx, coff;
  logic             chain, accept, flush_w;

`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign free_count  = free_q;
  assign disp_accept = accept;

  // Dispatch side: lane count, all-or-nothing acceptance and lane indices.
  always_comb begin
    n_disp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n_disp = n_disp + (IDX_W+1)'(disp_valid[i]);
      disp_idx[i] = tail_q + IDX_W'(i);
    end
    // Free space deliberately excludes this cycle's retires.
    accept = !flush_w && (n_disp <= free_q);
  end

  // Retire side: longest complete prefix starting at the head.
  always_comb begin
    chain        = 1'b1;
    n_ret        = '0;
    ridx         = '0;
    retire_valid = '0;
    retire_t     = '0;
    retire_t_old = '0;
    for (int k = 0; k < WIDTH; k++) begin
      ridx  = head_q + IDX_W'(k);
      chain = chain && ((IDX_W+1)'(k) < count_q) && cmpl_q[ridx];
      retire_valid[k] = chain;
      if (chain) begin
        retire_t[k]     = t_q[ridx];
        retire_t_old[k] = t_old_q[ridx];
      end
      n_ret = n_ret + (IDX_W+1)'(chain);
    end
  end

  // Next state of pointers, occupancy and complete bits.
  always_comb begin
    cmpl_d  = cmpl_q;
    coff    = '0;
    head_d  = head_q + n_ret[IDX_W-1:0];
    tail_d  = accept ? tail_q + n_disp[IDX_W-1:0] : tail_q;
    count_d = count_q + (accept ? n_disp : '0) - n_ret;
    if (!flush_w) begin
      for (int i = 0; i < WIDTH; i++) begin
        // Only entries between head and head+count are live.
        coff = cmpl_idx[i] - head_q;
        if (cmpl_en[i] && ({1'b0, coff} < count_q))
          cmpl_d[cmpl_idx[i]] = 1'b1;
      end
    end
    // Applied after completions so a colliding dispatch leaves the entry incomplete.
    for (int i = 0; i < WIDTH; i++) begin
      if (accept && disp_valid[i])
        cmpl_d[disp_idx[i]] = 1'b0;
    end
    if (flush_w) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      cmpl_d  = '0;
    end
    free_d = DEPTH_C - count_d;
  end

  // Control state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= DEPTH_C;
      cmpl_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= free_d;
      cmpl_q  <= cmpl_d;
    end
  end

  // Tag storage, written only by accepted dispatch lanes.
  always_ff @(posedge clock) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (accept && disp_valid[i]) begin
        t_q[disp_idx[i]]     <= disp_t[i];
        t_old_q[disp_idx[i]] <= disp_t_old[i];
      end
    end
  end

endmodule

// File: doc/rob_multiway.md
# rob_multiway

Parametrised reorder buffer that accepts up to `WIDTH` dispatched instructions per cycle and retires up to `WIDTH` completed instructions per cycle, strictly in program order. It sits between decode/rename (dispatch side), issue/complete (completion side) and the map table/free list (retire side). Each entry holds the new physical tag `t`, the previous mapping `t_old` and a complete bit. An optional flush clears all in-flight entries after a mispredict.

## Interface
- `DEPTH`, 32: number of entries; power of two, ≥ `WIDTH`.
- `WIDTH`, 2: dispatch, complete and retire lanes.
- `TAG_W`, 7: physical tag width; the tag bus carries `{valid, tag}`, so it is `TAG_W+1` bits.
- `IDX_W` = $clog2(`DEPTH`), derived.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `disp_valid`  in  `WIDTH`  per-lane dispatch request; lanes must be contiguous from lane 0.
- `disp_t`, `disp_t_old`  in  `WIDTH`×(`TAG_W`+1)  per-lane tags.
- `disp_idx`  out  `WIDTH`×`IDX_W`  entry index assigned to each lane (tail+i mod `DEPTH`).
- `free_count`  out  `IDX_W`+1  free entries, registered.
- `disp_accept`  out  1  all valid lanes accepted this cycle.
- `cmpl_en`  in  `WIDTH`  per-lane completion strobe.
- `cmpl_idx`  in  `WIDTH`×`IDX_W`  entry index to mark complete.
- `retire_valid`  out  `WIDTH`  per-lane retire strobe; a prefix mask.
- `retire_t`, `retire_t_old`  out  `WIDTH`×(`TAG_W`+1)  tags of the retiring entries, head first.
- `flush`  in  1  squash all entries (present only with `ROB_FLUSH_EN`).

## Operation
- State: entry array, `head`, `tail` (`IDX_W` bits, modular wrap) and `count` (0..`DEPTH`).
- `free_count` = `DEPTH` − `count`.
- Dispatch:
  - n = popcount(`disp_valid`). `disp_accept` = (n ≤ `free_count`).
  - Acceptance is all-or-nothing. When accepted, lane i writes entry tail+i with complete=0, and `tail` advances by n.
  - When rejected, nothing is written and `tail` holds. Upstream must hold its lanes until accepted.
  - Non-contiguous `disp_valid` is illegal; behaviour is undefined.
- Retire (combinational from registered state):
  - Lane k retires iff k < `count`, entry head+k is complete, and lanes 0..k−1 also retire.
  - `head` advances by r = popcount(`retire_valid`).
- Completion:
  - Each `cmpl_en` lane sets complete on `cmpl_idx`. Duplicate indices across lanes are harmless.
  - Completion of an unoccupied entry is ignored.
- Count update: next `count` = `count` + (accepted ? n : 0) − r.
  - Free space does not include same-cycle retires. Dispatch at `count`=`DEPTH` is rejected even if retiring.
- Same-cycle dispatch write and completion to the same index: the dispatch write wins (complete=0).
- Reset: `head`=`tail`=`count`=0, all complete bits 0, `free_count`=`DEPTH`, `retire_valid`=0, `disp_accept`=1 when `disp_valid`=0, `disp_idx` lane i = i.

## Timing
- Dispatched entries are visible to completion and retire one cycle after acceptance.
- Completion takes effect at the next edge. The entry can retire in the following cycle (1-cycle complete→retire latency).
- Retire outputs are valid in the same cycle the head entries are complete. The map table consumes them at that edge.
- Back-to-back full-width dispatch and retire are sustained with no bubbles; `free_count` stays constant.
- Wrap-around: indices are mod `DEPTH`, and a retire group may span entry `DEPTH`−1 → 0.
- Reset mid-operation discards all entries at the next edge. Retire outputs are 0 in the cycle after reset.

## Configuration
- `ROB_FLUSH_EN` defined:
  - The `flush` port exists. When `flush`=1, retire proceeds normally that cycle, while dispatch and completion are ignored and `disp_accept`=0.
  - At the edge, `head`=`tail`=`count`=0 and all complete bits clear. In the next cycle `free_count`=`DEPTH`.
- Undefined: the port is absent, and entries leave only through retire.

## Test plan
- Reset, then 2 lanes dispatch `t`=5/6 with `t_old`=1/2 → `disp_idx`=0/1, `free_count` 32→30 next cycle.
- Complete idx 1 only → no retire. Then complete idx 0 → next cycle `retire_valid`=2'b11 with `t`=5,6 and `t_old`=1,2.
- Fill to `count`=31, then dispatch 2 lanes → `disp_accept`=0, no state change. Dispatch 1 lane → accepted, `free_count`=0.
- Head at 31, entries 31 and 0 complete → both retire in one cycle; `head`=1.
- Same-cycle full dispatch, full retire and completion at `count`=16 → `count` stays 16; dispatch/complete collision on the same idx leaves the entry incomplete.
- With `ROB_FLUSH_EN`: 10 entries with the head complete, assert `flush` → head retires that cycle, next cycle `free_count`=32, `retire_valid`=0, `disp_idx`=0/1.
